// File: rtl/seg_disp_pkg.sv
// Shared types for the seven-segment display path:
// scan state, digit geometry and buffer layout.
package seg_disp_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int SEL_W      = 3;
    localparam int VALUE_W    = NUM_DIGITS * DIGIT_W;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    typedef logic [SEL_W-1:0]   sel_t;
    typedef logic [DIGIT_W-1:0] digit_t;

    typedef struct packed {
        logic [VALUE_W-1:0]    val;
        logic [NUM_DIGITS-1:0] mask;
    } disp_buf_t;

    function automatic digit_t nibble(
        input logic [VALUE_W-1:0] v,
        input sel_t               s
    );
        return v[int'(s) * DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_slot_timer.sv
// Per-slot cycle counter: flags the last cycle of a slot and
// the leading blanking interval used against ghosting.
module slot_timer
    import seg_disp_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_end,
    output logic in_blank
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam scan_state_t START =
        (BLANK_CYCLES == 0) ? SHOW : BLANK;

    generate
        if (TICK_DIV < 2 || BLANK_CYCLES < 0 ||
            BLANK_CYCLES >= TICK_DIV) begin : g_bad_param
            $error("slot_timer: need TICK_DIV>=2, 0<=BLANK_CYCLES<TICK_DIV");
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    scan_state_t   state;

    assign cnt_nxt  = cnt + CW'(1);
    assign slot_end = (cnt == LAST);
    assign in_blank = (state == BLANK);

    // state is registered alongside cnt so it tracks cnt < BLANK_CYCLES
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            state <= START;
        end else if (slot_end) begin
            cnt   <= '0;
            state <= START;
        end else begin
            cnt <= cnt_nxt;
            if (int'(cnt_nxt) < BLANK_CYCLES) begin
                state <= BLANK;
            end else begin
                state <= SHOW;
            end
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit display scan controller with double-buffered
// value/mask; new data is applied only at frame boundaries.
module seg_scan_ctrl
    import seg_disp_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VALUE_W-1:0]    value,
    input  logic [NUM_DIGITS-1:0] mask,
    input  logic                  load,
    output logic [DIGIT_W-1:0]    digit,
    output logic [SEL_W-1:0]      display_select,
    output logic                  blank,
    output logic                  frame_done,
    output logic                  update_pending
);

    sel_t      sel;
    disp_buf_t active;
    disp_buf_t pend;
    logic      pend_valid;
    logic      slot_end;
    logic      in_blank;
    logic      wrap;

    slot_timer #(
        .TICK_DIV    (TICK_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .slot_end(slot_end),
        .in_blank(in_blank)
    );

    assign wrap = slot_end && (sel == SEL_W'(NUM_DIGITS - 1));

    // transfer reads old pending before a coincident load overwrites it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel        <= '0;
            active     <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (slot_end) begin
                sel <= sel + SEL_W'(1);
            end
            if (wrap && pend_valid) begin
                active <= pend;
            end
            if (load) begin
                pend.val   <= value;
                pend.mask  <= mask;
                pend_valid <= 1'b1;
            end else if (wrap) begin
                pend_valid <= 1'b0;
            end
        end
    end

    assign digit          = nibble(active.val, sel);
    assign display_select = sel;
    assign blank          = in_blank | ~active.mask[sel];
    assign update_pending = pend_valid;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: vector table, corner sequences and
// random traffic against a cycle-count based reference model.
module tb_seg_scan_ctrl;

    localparam int TD = 4;
    localparam int BC = 1;
    localparam int FR = 8 * TD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  mask = '0;

    logic [3:0] digit, digit0;
    logic [2:0] sel, sel0;
    logic       blank, blank0;
    logic       fd, fd0;
    logic       up, up0;

    int checks = 0;
    int failures = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .mask(mask),
        .load(load), .digit(digit), .display_select(sel),
        .blank(blank), .frame_done(fd), .update_pending(up)
    );

    seg_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .value(value), .mask(mask),
        .load(load), .digit(digit0), .display_select(sel0),
        .blank(blank0), .frame_done(fd0), .update_pending(up0)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: time since reset plus the two buffers
    int          t = 0;
    logic [31:0] av = '0, pv = '0;
    logic [7:0]  am = '0, pm = '0;
    logic        pvalid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            t = 0; av = '0; am = '0; pv = '0; pm = '0; pvalid = 1'b0;
        end else begin
            t = t + 1;
            if ((t % FR) == 0 && pvalid) begin
                av = pv; am = pm; pvalid = 1'b0;
            end
            if (load) begin
                pv = value; pm = mask; pvalid = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            int s, ph;
            logic [3:0] ed;
            logic efd;
            s   = (t / TD) % 8;
            ph  = t % TD;
            ed  = av[4*s +: 4];
            efd = (t > 0) && ((t % FR) == 0);
            chk("m_sel", 32'(sel), s);
            chk("m_digit", 32'(digit), 32'(ed));
            chk("m_blank", 32'(blank), 32'((ph < BC) || !am[s]));
            chk("m_fd", 32'(fd), 32'(efd));
            chk("m_up", 32'(up), 32'(pvalid));
            chk("m0_sel", 32'(sel0), s);
            chk("m0_digit", 32'(digit0), 32'(ed));
            chk("m0_blank", 32'(blank0), 32'(!am[s]));
            chk("m0_fd", 32'(fd0), 32'(efd));
            chk("m0_up", 32'(up0), 32'(pvalid));
        end
    end

    task automatic cyc(input logic ld, input logic [31:0] v,
                       input logic [7:0] m);
        load = ld; value = v; mask = m;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_fd();
        int n = 0;
        while (!fd && n < 3 * FR) begin
            @(negedge clk);
            n++;
        end
        chk("fd_timeout", 32'(fd), 1);
    endtask

    typedef struct {
        logic [31:0] v;
        logic [7:0]  m;
        int          k;
        int          p;
        logic [3:0]  ed;
        logic        eb;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{32'h76543210, 8'hFF, 3, 0, 4'h3, 1'b1};
        tbl[1]  = '{32'h76543210, 8'hFF, 3, 2, 4'h3, 1'b0};
        tbl[2]  = '{32'h76543210, 8'h0F, 5, 1, 4'h5, 1'b1};
        tbl[3]  = '{32'h76543210, 8'h0F, 2, 3, 4'h2, 1'b0};
        tbl[4]  = '{32'h76543210, 8'h0F, 7, 3, 4'h7, 1'b1};
        tbl[5]  = '{32'hDEADBEEF, 8'hA5, 1, 1, 4'hE, 1'b1};
        tbl[6]  = '{32'hDEADBEEF, 8'hA5, 2, 1, 4'hE, 1'b0};
        tbl[7]  = '{32'hDEADBEEF, 8'hA5, 4, 2, 4'hD, 1'b1};
        tbl[8]  = '{32'hDEADBEEF, 8'hA5, 7, 0, 4'hD, 1'b1};
        tbl[9]  = '{32'hDEADBEEF, 8'hA5, 5, 3, 4'hA, 1'b0};
        tbl[10] = '{32'hDEADBEEF, 8'hA5, 0, 2, 4'hF, 1'b0};

        // reset state
        @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;
        chk("rst_sel", 32'(sel), 0);
        chk("rst_digit", 32'(digit), 0);
        chk("rst_blank", 32'(blank), 1);
        chk("rst_fd", 32'(fd), 0);
        chk("rst_up", 32'(up), 0);

        // first load waits for the frame boundary
        cyc(1'b1, 32'h76543210, 8'hFF);
        chk("load_up", 32'(up), 1);
        while (!fd && t < 2 * FR) begin
            chk("pre_frame_blank", 32'(blank), 1);
            @(negedge clk);
        end
        wait_fd();
        chk("first_fd_time", t, FR);
        chk("applied_up", 32'(up), 0);
        for (int k = 0; k < 8; k++) begin
            for (int p = 0; p < TD; p++) begin
                chk("f1_digit", 32'(digit), k);
                chk("f1_blank", 32'(blank), 32'(p == 0));
                @(negedge clk);
            end
        end

        // free-run three frames
        for (int c = 0; c < 3 * FR; c++) begin
            chk("run_sel", 32'(sel), (c / TD) % 8);
            chk("run_fd", 32'(fd), 32'((c % FR) == 0));
            @(negedge clk);
        end

        // vector table
        foreach (tbl[i]) begin
            do_reset();
            cyc(1'b1, tbl[i].v, tbl[i].m);
            wait_fd();
            idle(tbl[i].k * TD + tbl[i].p);
            chk("tbl_sel", 32'(sel), tbl[i].k);
            chk("tbl_digit", 32'(digit), 32'(tbl[i].ed));
            chk("tbl_blank", 32'(blank), 32'(tbl[i].eb));
        end

        // last load wins; load on the boundary is deferred a frame
        do_reset();
        cyc(1'b1, 32'h11111111, 8'hFF);
        idle(3);
        cyc(1'b1, 32'hAAAAAAAA, 8'hFF);
        wait_fd();
        chk("dbl_digit", 32'(digit), 32'hA);
        idle(FR - 1);
        cyc(1'b1, 32'hBBBBBBBB, 8'hFF);
        chk("bnd_fd", 32'(fd), 1);
        chk("bnd_digit", 32'(digit), 32'hA);
        chk("bnd_up", 32'(up), 1);
        idle(1);
        wait_fd();
        chk("bnd_next_digit", 32'(digit), 32'hB);
        chk("bnd_next_up", 32'(up), 0);

        // reset mid-slot with a load pending; load during reset ignored
        do_reset();
        cyc(1'b1, 32'h12345678, 8'hFF);
        wait_fd();
        cyc(1'b1, 32'h9ABCDEF0, 8'hFF);
        begin
            int n = 0;
            while (sel != 3'd5 && n < 2 * FR) begin
                @(negedge clk);
                n++;
            end
        end
        idle(1);
        chk("mid_sel", 32'(sel), 5);
        chk("mid_up", 32'(up), 1);
        rst_n = 1'b0;
        load = 1'b1;
        value = 32'hFFFFFFFF;
        mask = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        load = 1'b0;
        chk("mrst_sel", 32'(sel), 0);
        chk("mrst_digit", 32'(digit), 0);
        chk("mrst_blank", 32'(blank), 1);
        chk("mrst_up", 32'(up), 0);
        chk("mrst_fd", 32'(fd), 0);

        // random traffic, checked by the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) begin
                rst_n = 1'b0;
                load = 1'($urandom_range(1));
                value = $urandom;
                @(negedge clk);
                rst_n = 1'b1;
                load = 1'b0;
            end else begin
                cyc($urandom_range(5) == 0, $urandom, 8'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
